// File: rtl/micro_op_queue_if.sv
// Front-end enqueue / decode-head bus for micro_op_queue.
// The queue takes the slave modport; the front end / decode side takes master.
interface micro_op_queue_if #(
  parameter int unsigned DEPTH_LOG  = 3,
  parameter int unsigned MICRO_W    = 8,
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned IMM_W      = 32,
  parameter int unsigned BIT_MODE_W = 2,
  parameter int unsigned ADDR_W     = 32
);
  logic                  enq_valid;
  logic                  enq_ready;
  logic [MICRO_W-1:0]    enq_opcode;
  logic [REG_ADDR_W-1:0] enq_reg_addr_d;
  logic [REG_ADDR_W-1:0] enq_reg_addr_s;
  logic [REG_ADDR_W-1:0] enq_reg_addr_t;
  logic [IMM_W-1:0]      enq_immediate;
  logic [BIT_MODE_W-1:0] enq_bit_mode;
  logic                  enq_efl_mode;
  logic [ADDR_W-1:0]     enq_pc;

  logic [MICRO_W-1:0]    deq_opcode_head;
  logic [REG_ADDR_W-1:0] deq_reg_addr_d_head;
  logic [REG_ADDR_W-1:0] deq_reg_addr_s_head;
  logic [REG_ADDR_W-1:0] deq_reg_addr_t_head;
  logic [IMM_W-1:0]      deq_immediate_head;
  logic [BIT_MODE_W-1:0] deq_bit_mode_head;
  logic                  deq_efl_mode_head;
  logic [ADDR_W-1:0]     deq_pc_head;
  logic                  deq_valid;

  logic [DEPTH_LOG:0]    count;
  logic                  stall;
  logic                  flush;

  modport master (
    output enq_valid, enq_opcode, enq_reg_addr_d, enq_reg_addr_s, enq_reg_addr_t,
           enq_immediate, enq_bit_mode, enq_efl_mode, enq_pc, stall, flush,
    input  enq_ready, deq_opcode_head, deq_reg_addr_d_head, deq_reg_addr_s_head,
           deq_reg_addr_t_head, deq_immediate_head, deq_bit_mode_head,
           deq_efl_mode_head, deq_pc_head, deq_valid, count
  );

  modport slave (
    input  enq_valid, enq_opcode, enq_reg_addr_d, enq_reg_addr_s, enq_reg_addr_t,
           enq_immediate, enq_bit_mode, enq_efl_mode, enq_pc, stall, flush,
    output enq_ready, deq_opcode_head, deq_reg_addr_d_head, deq_reg_addr_s_head,
           deq_reg_addr_t_head, deq_immediate_head, deq_bit_mode_head,
           deq_efl_mode_head, deq_pc_head, deq_valid, count
  );
endinterface

// File: rtl/micro_op_queue.sv
// Micro-op FIFO between the x86 front end and decode_phase; flush drops all entries.
// Define MICRO_OP_QUEUE_BYPASS_EN for zero-latency empty-queue bypass.
module micro_op_queue #(
  parameter int unsigned DEPTH_LOG  = 3,
  parameter int unsigned MICRO_W    = 8,
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned IMM_W      = 32,
  parameter int unsigned BIT_MODE_W = 2,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic             clk,
  input  logic             rstn,
  micro_op_queue_if.slave  bus
);
  localparam int unsigned DEPTH   = 2 ** DEPTH_LOG;
  localparam int unsigned ENTRY_W = MICRO_W + 3 * REG_ADDR_W + IMM_W + BIT_MODE_W + 1 + ADDR_W;
  localparam logic [DEPTH_LOG:0] FULL_CNT = (DEPTH_LOG + 1)'(DEPTH);

  logic [ENTRY_W-1:0]   r_mem [DEPTH];
  logic [DEPTH_LOG-1:0] r_rp;
  logic [DEPTH_LOG-1:0] r_wp;
  logic [DEPTH_LOG:0]   r_count;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_bypass;
  logic                 w_push;
  logic                 w_pop;
  logic [ENTRY_W-1:0]   w_enq_entry;
  logic [ENTRY_W-1:0]   w_head_entry;

  assign w_enq_entry = {bus.enq_opcode, bus.enq_reg_addr_d, bus.enq_reg_addr_s,
                        bus.enq_reg_addr_t, bus.enq_immediate, bus.enq_bit_mode,
                        bus.enq_efl_mode, bus.enq_pc};

  always_comb begin
    w_full   = (r_count == FULL_CNT);
    w_empty  = (r_count == '0);
`ifdef MICRO_OP_QUEUE_BYPASS_EN
    w_bypass = w_empty & bus.enq_valid & ~bus.flush;
`else
    w_bypass = 1'b0;
`endif
    // A bypassed micro-op that decode takes this cycle never touches storage.
    w_push   = bus.enq_valid & ~w_full & ~bus.flush & ~(w_bypass & ~bus.stall);
    w_pop    = ~bus.stall & ~w_empty & ~bus.flush;
  end

  always_comb begin
    w_head_entry = '0;
    if (w_bypass) begin
      w_head_entry = w_enq_entry;
    end else if (!w_empty) begin
      w_head_entry = r_mem[r_rp];
    end
  end

  assign {bus.deq_opcode_head, bus.deq_reg_addr_d_head, bus.deq_reg_addr_s_head,
          bus.deq_reg_addr_t_head, bus.deq_immediate_head, bus.deq_bit_mode_head,
          bus.deq_efl_mode_head, bus.deq_pc_head} = w_head_entry;

  assign bus.deq_valid = ~w_empty | w_bypass;
  assign bus.enq_ready = ~w_full;
  assign bus.count     = r_count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rp    <= '0;
      r_wp    <= '0;
      r_count <= '0;
    end else if (bus.flush) begin
      r_rp    <= '0;
      r_wp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + DEPTH_LOG'(1);
      if (w_pop)  r_rp <= r_rp + DEPTH_LOG'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (DEPTH_LOG + 1)'(1);
        2'b01:   r_count <= r_count - (DEPTH_LOG + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is intentionally not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= w_enq_entry;
  end
endmodule

// File: tb/tb_micro_op_queue.sv
// Directed self-checking bench for micro_op_queue (default depth 8).
module tb_micro_op_queue;
  logic clk;
  logic rstn;
  int   n_vec;
  int   n_err;

  micro_op_queue_if bus ();

  micro_op_queue #(
    .DEPTH_LOG (3),
    .MICRO_W   (8),
    .REG_ADDR_W(4),
    .IMM_W     (32),
    .BIT_MODE_W(2),
    .ADDR_W    (32)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (actual still running, required finished)");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic valid, input logic [7:0] op);
    bus.enq_valid      = valid;
    bus.enq_opcode     = op;
    bus.enq_reg_addr_d = op[3:0];
    bus.enq_reg_addr_s = op[7:4];
    bus.enq_reg_addr_t = ~op[3:0];
    bus.enq_immediate  = {op, op, op, op};
    bus.enq_bit_mode   = op[1:0];
    bus.enq_efl_mode   = op[0];
    bus.enq_pc         = {22'h0, op, 2'b00};
  endtask

  task automatic test_reset;
    rstn      = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    drive(1'b0, 8'h00);
    #1;
    n_vec++; if (bus.enq_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", bus.enq_ready); end
    n_vec++; if (bus.deq_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.deq_valid); end
    n_vec++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    n_vec++; if (bus.deq_pc_head !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want 0", bus.deq_pc_head); end
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_fill_drain;
    bus.stall = 1'b1;
    drive(1'b1, 8'hA1); tick();
    drive(1'b1, 8'hB2); tick();
    drive(1'b1, 8'hC3); tick();
    drive(1'b0, 8'h00);
    #1;
    n_vec++; if (bus.count !== 4'd3) begin n_err++; $display("FAIL fd_count: got %0d want 3", bus.count); end
    n_vec++; if (bus.deq_opcode_head !== 8'hA1) begin n_err++; $display("FAIL fd_headA: got %h want a1", bus.deq_opcode_head); end
    n_vec++; if (bus.deq_valid !== 1'b1) begin n_err++; $display("FAIL fd_valid: got %b want 1", bus.deq_valid); end
    n_vec++; if (bus.deq_reg_addr_t_head !== 4'hE) begin n_err++; $display("FAIL fd_regt: got %h want e", bus.deq_reg_addr_t_head); end
    bus.stall = 1'b0;
    tick(); #1;
    n_vec++; if (bus.deq_opcode_head !== 8'hB2) begin n_err++; $display("FAIL fd_headB: got %h want b2", bus.deq_opcode_head); end
    n_vec++; if (bus.deq_pc_head !== 32'h2C8) begin n_err++; $display("FAIL fd_pcB: got %h want 2c8", bus.deq_pc_head); end
    tick(); #1;
    n_vec++; if (bus.deq_opcode_head !== 8'hC3) begin n_err++; $display("FAIL fd_headC: got %h want c3", bus.deq_opcode_head); end
    n_vec++; if (bus.deq_efl_mode_head !== 1'b1) begin n_err++; $display("FAIL fd_eflC: got %b want 1", bus.deq_efl_mode_head); end
    tick(); #1;
    n_vec++; if (bus.deq_opcode_head !== 8'h00) begin n_err++; $display("FAIL fd_head0: got %h want 00", bus.deq_opcode_head); end
    n_vec++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL fd_count0: got %0d want 0", bus.count); end
    n_vec++; if (bus.deq_valid !== 1'b0) begin n_err++; $display("FAIL fd_valid0: got %b want 0", bus.deq_valid); end
  endtask

  task automatic test_full;
    bus.stall = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'h20 + 8'(i));
      tick();
    end
    drive(1'b1, 8'h99);
    #1;
    n_vec++; if (bus.count !== 4'd8) begin n_err++; $display("FAIL full_count: got %0d want 8", bus.count); end
    n_vec++; if (bus.enq_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b want 0", bus.enq_ready); end
    tick(); #1;
    n_vec++; if (bus.count !== 4'd8) begin n_err++; $display("FAIL full_ninth: got %0d want 8", bus.count); end
    bus.stall = 1'b0;
    tick();
    bus.stall = 1'b1;
    #1;
    n_vec++; if (bus.count !== 4'd7) begin n_err++; $display("FAIL full_pop: got %0d want 7", bus.count); end
    n_vec++; if (bus.enq_ready !== 1'b1) begin n_err++; $display("FAIL full_ready1: got %b want 1", bus.enq_ready); end
    n_vec++; if (bus.deq_opcode_head !== 8'h21) begin n_err++; $display("FAIL full_head: got %h want 21", bus.deq_opcode_head); end
    n_vec++; if (bus.deq_immediate_head !== 32'h21212121) begin n_err++; $display("FAIL full_imm: got %h want 21212121", bus.deq_immediate_head); end
    drive(1'b0, 8'h00);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    #1;
    n_vec++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL full_flushed: got %0d want 0", bus.count); end
  endtask

  task automatic test_stream;
    logic [7:0] prev;
    bus.stall = 1'b0;
    prev = 8'h40;
    drive(1'b1, 8'h40);
    tick();
    for (int i = 1; i < 20; i++) begin
      drive(1'b1, 8'h40 + 8'(i));
      #1;
`ifdef MICRO_OP_QUEUE_BYPASS_EN
      n_vec++; if (bus.deq_opcode_head !== 8'h40 + 8'(i)) begin n_err++; $display("FAIL stream_head[%0d]: got %h want %h", i, bus.deq_opcode_head, 8'h40 + 8'(i)); end
      n_vec++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL stream_count[%0d]: got %0d want 0", i, bus.count); end
`else
      n_vec++; if (bus.deq_opcode_head !== prev) begin n_err++; $display("FAIL stream_head[%0d]: got %h want %h", i, bus.deq_opcode_head, prev); end
      n_vec++; if (bus.count !== 4'd1) begin n_err++; $display("FAIL stream_count[%0d]: got %0d want 1", i, bus.count); end
`endif
      prev = 8'h40 + 8'(i);
      tick();
    end
    drive(1'b0, 8'h00);
    tick(); #1;
    n_vec++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL stream_drain: got %0d want 0", bus.count); end
  endtask

  task automatic test_flush;
    bus.stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'h60 + 8'(i));
      tick();
    end
    #1;
    n_vec++; if (bus.count !== 4'd5) begin n_err++; $display("FAIL flush_pre: got %0d want 5", bus.count); end
    drive(1'b1, 8'hEE);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    drive(1'b0, 8'h00);
    #1;
    n_vec++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL flush_count: got %0d want 0", bus.count); end
    n_vec++; if (bus.deq_opcode_head !== 8'h00) begin n_err++; $display("FAIL flush_head: got %h want 00", bus.deq_opcode_head); end
    n_vec++; if (bus.enq_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready: got %b want 1", bus.enq_ready); end
    bus.stall = 1'b0;
    tick(); tick(); #1;
    n_vec++; if (bus.deq_valid !== 1'b0) begin n_err++; $display("FAIL flush_dropped: got %b want 0", bus.deq_valid); end
  endtask

  task automatic test_async_reset;
    bus.stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'h70 + 8'(i));
      tick();
    end
    drive(1'b0, 8'h00);
    #1;
    n_vec++; if (bus.count !== 4'd4) begin n_err++; $display("FAIL areset_pre: got %0d want 4", bus.count); end
    rstn = 1'b0;
    #1;
    n_vec++; if (bus.deq_valid !== 1'b0) begin n_err++; $display("FAIL areset_valid: got %b want 0", bus.deq_valid); end
    n_vec++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL areset_count: got %0d want 0", bus.count); end
    n_vec++; if (bus.enq_ready !== 1'b1) begin n_err++; $display("FAIL areset_ready: got %b want 1", bus.enq_ready); end
    n_vec++; if (bus.deq_opcode_head !== 8'h00) begin n_err++; $display("FAIL areset_head: got %h want 00", bus.deq_opcode_head); end
    tick();
    rstn = 1'b1;
    bus.stall = 1'b0;
    tick();
  endtask

  task automatic test_latency;
    bus.stall = 1'b0;
    drive(1'b1, 8'h10);
    #1;
`ifdef MICRO_OP_QUEUE_BYPASS_EN
    n_vec++; if (bus.deq_pc_head !== 32'h40) begin n_err++; $display("FAIL byp_pc: got %h want 40", bus.deq_pc_head); end
    n_vec++; if (bus.deq_valid !== 1'b1) begin n_err++; $display("FAIL byp_valid: got %b want 1", bus.deq_valid); end
    tick();
    drive(1'b0, 8'h00);
    #1;
    n_vec++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL byp_count: got %0d want 0", bus.count); end
    bus.stall = 1'b1;
    drive(1'b1, 8'h10);
    #1;
    n_vec++; if (bus.deq_pc_head !== 32'h40) begin n_err++; $display("FAIL byp_stall_pc: got %h want 40", bus.deq_pc_head); end
    tick();
    drive(1'b0, 8'h00);
    #1;
    n_vec++; if (bus.count !== 4'd1) begin n_err++; $display("FAIL byp_stall_count: got %0d want 1", bus.count); end
`else
    n_vec++; if (bus.deq_valid !== 1'b0) begin n_err++; $display("FAIL lat_same: got %b want 0", bus.deq_valid); end
    tick();
    drive(1'b0, 8'h00);
    #1;
    n_vec++; if (bus.deq_pc_head !== 32'h40) begin n_err++; $display("FAIL lat_pc: got %h want 40", bus.deq_pc_head); end
    n_vec++; if (bus.count !== 4'd1) begin n_err++; $display("FAIL lat_count: got %0d want 1", bus.count); end
    tick(); #1;
    n_vec++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL lat_pop: got %0d want 0", bus.count); end
`endif
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_fill_drain();
    test_full();
    test_stream();
    test_flush();
    test_async_reset();
    test_latency();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/micro_op_queue.md
# micro_op_queue

Micro-op FIFO sitting between the x86 instruction front end and `decode_phase`. It accepts at most one micro-op per cycle from the front end and presents the oldest entry on the `deq_*_head` bus, which `decode_phase` consumes. Each micro-op carries opcode, three register addresses, immediate, bit mode, EFLAGS mode and PC. The queue pops on every cycle without stall, and drops all content on flush (branch redirect).

## Interface
- `DEPTH_LOG`, default 3: log2 of the entry count, so the default depth is 8.
- `clk` in 1: clock; all state updates on the rising edge.
- `rstn` in 1: reset, asynchronous, active-low.
- `enq_valid` in 1: the front end offers a micro-op.
- `enq_ready` out 1: the queue can accept a micro-op this cycle; equals `~full`.
- `enq_opcode` in `MICRO_W`: micro-op opcode.
- `enq_reg_addr_d` / `enq_reg_addr_s` / `enq_reg_addr_t` in `REG_ADDR_W` each: register addresses.
- `enq_immediate` in `IMM_W`: immediate field.
- `enq_bit_mode` in `BIT_MODE_W`: operand size mode.
- `enq_efl_mode` in 1: EFLAGS update enable.
- `enq_pc` in `ADDR_W`: PC of the originating instruction.
- `deq_opcode_head`, `deq_reg_addr_d_head`, `deq_reg_addr_s_head`, `deq_reg_addr_t_head`, `deq_immediate_head`, `deq_bit_mode_head`, `deq_efl_mode_head`, `deq_pc_head` out (matching widths): head entry fields.
- `deq_valid` out 1: the head is a real entry.
- `count` out `DEPTH_LOG+1`: current occupancy.
- `stall` in 1: decode holds this cycle; no pop.
- `flush` in 1: discard all entries.

## Operation
- Storage: `2**DEPTH_LOG` entries, read pointer `rp`, write pointer `wp` (`DEPTH_LOG` bits each), and `count`.
- `full` = (`count == 2**DEPTH_LOG`); `empty` = (`count == 0`).
- Push when `enq_valid & enq_ready & ~flush`: write the entry at `wp`, then `wp` increments.
- Pop when `~stall & ~empty & ~flush`: `rp` increments.
- Pointers wrap modulo `2**DEPTH_LOG` with natural binary overflow.
- `count` update: +1 on push only, -1 on pop only, unchanged on push and pop together.
- Push and pop in the same cycle are legal whenever not full. When full, `enq_ready` is 0, so no push occurs even if a pop happens that cycle. `enq_ready` depends only on registered `count`.
- Head outputs are combinational from the entry at `rp`.
- When empty, all `deq_*_head` outputs are 0 (`MICRO_NOP`), and `deq_valid` is 0.
- Flush has priority over everything: next cycle `rp = wp = count = 0`. A push offered in the flush cycle is dropped.
- Stall and flush together: flush wins.
- A push while stalled still writes if not full.

## Timing
- Reset (async, `rstn` low): `rp`, `wp`, `count` are 0.
  - `enq_ready` = 1, `deq_valid` = 0, all head outputs are 0, immediately and without waiting for a clock.
  - Storage contents are not reset.
  - Reset mid-operation discards all entries.
- Enqueue-to-head latency is 1 cycle: a push at edge N appears on the head after edge N.
- A pop at edge N exposes the next entry after edge N (or zeros if the queue became empty).
- Throughput: 1 push and 1 pop per cycle sustained.
- After a flush edge: `enq_ready` = 1 and the head is zeros in the following cycle.

## Configuration
- `MICRO_OP_QUEUE_BYPASS_EN` defined:
  - When the queue is empty and `enq_valid & ~flush`, the head outputs show the `enq_*` inputs combinationally and `deq_valid` is 1.
  - If `~stall` that cycle, the micro-op is consumed directly: no storage write, pointers and `count` unchanged.
  - If `stall`, it is written normally (push).
  - Enqueue-to-head latency becomes 0 cycles when the queue is empty.
- Not defined: no bypass; behaviour is exactly as in Operation and Timing.

## Test plan
- Reset, then push opcodes A, B, C on 3 consecutive cycles with `stall` = 1: `count` = 3; head = A; `deq_valid` = 1; releasing stall pops A, B, C over 3 cycles, after which the head is 0 and `count` = 0.
- Fill all 8 entries with `stall` = 1: `enq_ready` = 0, a 9th push is ignored, `count` stays 8. Release stall for 1 cycle with `enq_valid` held: one pop, no push, `count` = 7, `enq_ready` = 1.
- Stream 20 micro-ops with push and pop every cycle: the head sequence equals the input sequence one cycle late, `count` holds 1, and the pointers wrap twice without loss.
- Fill with 5 entries, then assert `flush` together with `enq_valid` and `stall`: next cycle `count` = 0, head is 0, and the flushed-cycle micro-op never appears.
- Assert `rstn` = 0 asynchronously mid-stream with 4 entries held: `deq_valid` and `count` drop to 0 before the next clock edge, and `enq_ready` = 1.
- With `MICRO_OP_QUEUE_BYPASS_EN`, empty queue, push PC = 0x40 with `stall` = 0: `deq_pc_head` = 0x40 in the same cycle and `count` stays 0. Repeat with `stall` = 1: `count` = 1 next cycle.
